// File: rtl/divider_iterative.sv
// Unsigned restoring divider. It accepts one dividend/divisor pair, produces one quotient bit
// per clock, and then pulses valid_out with the quotient and remainder.
module divider_iterative #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             valid_in,
   output logic             ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             valid_out,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] r
);

   localparam int unsigned CntW = $clog2(WIDTH);

   typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] rem_q, rem_d;
   logic [WIDTH-1:0] quo_q, quo_d;
   logic [WIDTH-1:0] div_q, div_d;
   logic [WIDTH-1:0] q_q, q_d;
   logic [WIDTH-1:0] r_q, r_d;
   logic [CntW-1:0]  cnt_q, cnt_d;

   logic [WIDTH:0]   rem_sh;
   logic [WIDTH:0]   trial;
   logic             trial_ge;
   logic             unused_trial_msb;

   // The shifted partial remainder needs one extra bit so that a dividend MSB shifted in is
   // not lost before the compare.
   assign rem_sh           = {rem_q, quo_q[WIDTH-1]};
   assign trial            = rem_sh - {1'b0, div_q};
   assign trial_ge         = rem_sh >= {1'b0, div_q};
   assign unused_trial_msb = trial[WIDTH];

   always_comb begin
      state_d   = state_q;
      rem_d     = rem_q;
      quo_d     = quo_q;
      div_d     = div_q;
      q_d       = q_q;
      r_d       = r_q;
      cnt_d     = cnt_q;
      ready     = 1'b0;
      valid_out = 1'b0;

      unique case (state_q)
         StIdle: begin
            ready = 1'b1;
            if (valid_in) begin
               quo_d   = a;
               div_d   = b;
               rem_d   = '0;
               cnt_d   = '0;
               state_d = StBusy;
            end
         end
         StBusy: begin
            rem_d = trial_ge ? trial[WIDTH-1:0] : rem_sh[WIDTH-1:0];
            quo_d = {quo_q[WIDTH-2:0], trial_ge};
            cnt_d = cnt_q + CntW'(1);
            if (cnt_q == CntW'(WIDTH - 1)) begin
               q_d     = quo_d;
               r_d     = rem_d;
               state_d = StDone;
            end
         end
         StDone: begin
            valid_out = 1'b1;
            state_d   = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StIdle;
         rem_q   <= '0;
         quo_q   <= '0;
         div_q   <= '0;
         q_q     <= '0;
         r_q     <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         rem_q   <= rem_d;
         quo_q   <= quo_d;
         div_q   <= div_d;
         q_q     <= q_d;
         r_q     <= r_d;
         cnt_q   <= cnt_d;
      end
   end

   assign q = q_q;
   assign r = r_q;

endmodule
